// File: rtl/rc4_pkg.sv
// Shared widths and FSM encodings for the RC4 keystream consumer.
// Imported by the FIFO and the XOR stream top.
package rc4_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte FIFO, DEPTH entries (power of 2), head presented combinationally.
// Latency: a byte pushed in cycle N is at dout from cycle N+1 (no bypass).
// Backpressure: pushes while full and pops while empty are ignored.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BYTE_W-1:0]         din,
    output logic [BYTE_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs plaintext with buffered RC4 keystream, counting bytes to msg_len then raising done.
// Latency: 1 cycle from plaintext accept to ct_valid; 1 byte/cycle with ct_ready high.
// Backpressure: ct_ready low holds ct_data/ct_valid and drops pt_ready; ks_ready low when FIFO full.
module rc4_xor_stream
    import rc4_pkg::*;
#(
    parameter int KS_DEPTH = 4,
    parameter int LEN_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              ks_valid,
    input  logic [BYTE_W-1:0] ks_byte,
    output logic              ks_ready,
    input  logic              pt_valid,
    input  logic [BYTE_W-1:0] pt_data,
    output logic              pt_ready,
    output logic              ct_valid,
    output logic [BYTE_W-1:0] ct_data,
    input  logic              ct_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(KS_DEPTH) + 1;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [BYTE_W-1:0] ks_head;
    logic [CW-1:0]     ks_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fire;
    logic              unused_ks_count;

    assign unused_ks_count = ^ks_count;

    rc4_ks_fifo #(
        .DEPTH (KS_DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ks_valid && ks_ready),
        .pop   (fire),
        .din   (ks_byte),
        .dout  (ks_head),
        .count (ks_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Full flag comes from the registered count, so a same-cycle pop never frees a slot early.
    assign ks_ready = !fifo_full;
    assign busy     = (state == ST_RUN);
    assign pt_ready = (state == ST_RUN) && !fifo_empty && (cnt < len_q)
                      && (!ct_valid || ct_ready);
    assign fire     = pt_valid && pt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            cnt      <= '0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_q <= msg_len;
                        cnt   <= '0;
                        if (msg_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        ct_data  <= pt_data ^ ks_head;
                        ct_valid <= 1'b1;
                        cnt      <= cnt + 1'b1;
                    end else if (ct_ready) begin
                        ct_valid <= 1'b0;
                    end
                    // cnt == len_q blocks further fires, so this is the final byte leaving.
                    if (ct_valid && ct_ready && (cnt == len_q)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed vector bench for rc4_xor_stream: keystream/plaintext/ciphertext tables plus
// hand-written sequences for backpressure, FIFO-full, zero length and mid-run reset.
module tb_rc4_xor_stream;

    typedef struct {
        logic [7:0] ks;
        logic [7:0] pt;
        logic [7:0] ct;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] msg_len;
    logic       ks_valid;
    logic [7:0] ks_byte;
    logic       ks_ready;
    logic       pt_valid;
    logic [7:0] pt_data;
    logic       pt_ready;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic       ct_ready;
    logic       busy;
    logic       done;

    int   applied     = 0;
    int   miscompares = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    rc4_xor_stream #(
        .KS_DEPTH (4),
        .LEN_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .msg_len  (msg_len),
        .ks_valid (ks_valid),
        .ks_byte  (ks_byte),
        .ks_ready (ks_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ks(input logic [7:0] b);
        @(negedge clk);
        ks_valid = 1'b1;
        ks_byte  = b;
        @(negedge clk);
        ks_valid = 1'b0;
    endtask

    task automatic start_msg(input logic [7:0] len);
        @(negedge clk);
        start   = 1'b1;
        msg_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Streams vecs[first +: n] through the DUT; optionally stalls ct_ready for 3 cycles
    // once ciphertext index stall_at is presented.
    task automatic run_msg(input int first, input int n, input int stall_at);
        int pt_idx = 0;
        int ct_idx = 0;
        int stall_cnt = 0;
        int cyc = 0;
        while (ct_idx < n && cyc < 200) begin
            @(negedge clk);
            pt_valid = (pt_idx < n);
            pt_data  = (pt_idx < n) ? vecs[first + pt_idx].pt : 8'h00;
            if (ct_valid && ct_idx == stall_at && stall_cnt < 3) begin
                ct_ready = 1'b0;
                #1;
                check("stall ct_data held", ct_data, vecs[first + ct_idx].ct);
                check("stall pt_ready low", pt_ready, 1'b0);
                stall_cnt++;
            end else begin
                ct_ready = 1'b1;
                #1;
                if (pt_valid && pt_ready) pt_idx++;
                if (ct_valid) begin
                    check("ct_data", ct_data, vecs[first + ct_idx].ct);
                    ct_idx++;
                    if (ct_idx == n) check("done low before last accept", done, 1'b0);
                end
            end
            cyc++;
        end
        if (ct_idx != n) check("message timeout", ct_idx, n);
        @(negedge clk);
        pt_valid = 1'b0;
        #1;
        check("done after last accept", done, 1'b1);
        check("busy after last accept", busy, 1'b0);
        check("ct_valid after last accept", ct_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{ks: 8'hDE, pt: 8'h00, ct: 8'hDE};
        vecs[1] = '{ks: 8'hAD, pt: 8'hFF, ct: 8'h52};
        vecs[2] = '{ks: 8'hBE, pt: 8'h12, ct: 8'hAC};
        vecs[3] = '{ks: 8'hEF, pt: 8'h34, ct: 8'hDB};
        vecs[4] = '{ks: 8'h01, pt: 8'h10, ct: 8'h11};
        vecs[5] = '{ks: 8'h02, pt: 8'h20, ct: 8'h22};
        vecs[6] = '{ks: 8'h03, pt: 8'h30, ct: 8'h33};
        vecs[7] = '{ks: 8'h04, pt: 8'h40, ct: 8'h44};
        vecs[8] = '{ks: 8'h3C, pt: 8'h0F, ct: 8'h33};
        vecs[9] = '{ks: 8'hC3, pt: 8'h00, ct: 8'hC3};

        rst_n    = 1'b0;
        start    = 1'b0;
        msg_len  = 8'd0;
        ks_valid = 1'b0;
        ks_byte  = 8'h00;
        pt_valid = 1'b0;
        pt_data  = 8'h00;
        ct_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("reset ks_ready", ks_ready, 1'b1);
        check("reset pt_ready", pt_ready, 1'b0);
        check("reset ct_valid", ct_valid, 1'b0);
        check("reset ct_data", ct_data, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill FIFO, offer a 5th byte while full, then run the first message
        for (int i = 0; i < 4; i++) push_ks(vecs[i].ks);
        #1;
        check("ks_ready when full", ks_ready, 1'b0);
        push_ks(8'h77);
        start_msg(8'd4);
        #1;
        check("busy in run", busy, 1'b1);
        check("done cleared in run", done, 1'b0);
        run_msg(0, 4, -1);

        // Second message from DONE with a 3-cycle ct_ready stall; wrong bytes here
        // would reveal a stored 5th keystream byte
        for (int i = 4; i < 8; i++) push_ks(vecs[i].ks);
        start_msg(8'd4);
        run_msg(4, 4, 1);

        // Mid-run reset with a ciphertext byte pending
        push_ks(8'hA5);
        push_ks(8'h5A);
        start_msg(8'd3);
        @(negedge clk);
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        pt_data  = 8'h00;
        @(negedge clk);
        pt_valid = 1'b0;
        #1;
        check("pending ct before reset", ct_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset ct_valid", ct_valid, 1'b0);
        check("async reset ct_data", ct_data, 8'h00);
        check("async reset busy", busy, 1'b0);
        check("async reset ks_ready", ks_ready, 1'b1);
        @(negedge clk);
        rst_n    = 1'b1;
        ct_ready = 1'b1;

        // Zero-length message from IDLE
        start_msg(8'd0);
        #1;
        check("len0 done", done, 1'b1);
        check("len0 busy", busy, 1'b0);
        @(negedge clk);
        pt_valid = 1'b1;
        #1;
        check("len0 pt_ready", pt_ready, 1'b0);
        check("len0 ct_valid", ct_valid, 1'b0);
        @(negedge clk);
        pt_valid = 1'b0;
        #1;
        check("len0 ct_valid later", ct_valid, 1'b0);

        // Fresh message after reset: stale A5/5A must be gone
        push_ks(vecs[8].ks);
        push_ks(vecs[9].ks);
        start_msg(8'd2);
        run_msg(8, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
